// File: rtl/control_sequencer_pkg.sv
// Shared opcodes, ALU selects, sequencer states, decoded instruction classes
// and the bundle of datapath strobes used by the control sequencer.
package control_sequencer_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_ALU_R, C_ALU_I, C_LDI, C_LD, C_ST, C_BR, C_NOP, C_HALT, C_ILLEGAL
  } op_class_e;

  typedef struct packed {
    logic pc_out, zhi_out, zlo_out, mdr_out, inport_out;
    logic mar_in, z_in, pc_in, mdr_in, ir_in, y_in, outport_in;
    logic inc_pc, rd, wr, gra, grb, grc, r_in, r_out, ba_out, c_out, con_in;
  } ctl_t;

endpackage

// File: rtl/control_sequencer_op_decoder.sv
// Maps the opcode field to an instruction class and the ALU operation it uses.
module control_sequencer_op_decoder
  import control_sequencer_pkg::*;
(
  input  logic [4:0] i_op,
  output op_class_e  o_cls,
  output logic [3:0] o_alu_sel
);

  always_comb begin
    o_cls     = C_ILLEGAL;
    o_alu_sel = ALU_ADD;
    case (i_op)
      OP_LD:   o_cls = C_LD;
      OP_LDI:  o_cls = C_LDI;
      OP_ST:   o_cls = C_ST;
      OP_ADD:  o_cls = C_ALU_R;
      OP_SUB:  begin o_cls = C_ALU_R; o_alu_sel = ALU_SUB; end
      OP_AND:  begin o_cls = C_ALU_R; o_alu_sel = ALU_AND; end
      OP_OR:   begin o_cls = C_ALU_R; o_alu_sel = ALU_OR;  end
      OP_ADDI: o_cls = C_ALU_I;
      OP_ANDI: begin o_cls = C_ALU_I; o_alu_sel = ALU_AND; end
      OP_ORI:  begin o_cls = C_ALU_I; o_alu_sel = ALU_OR;  end
      OP_BR:   o_cls = C_BR;
      OP_NOP:  o_cls = C_NOP;
      OP_HALT: o_cls = C_HALT;
      default: o_cls = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T0..T7 control unit for the single-bus datapath, with memory
// wait-state handshake, bus-error timeout and halt/stop handling.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int OPW         = 5,
  parameter int ALUW        = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            Clock,
  input  logic            Clear,
  input  logic [31:0]     IR,
  input  logic            CON_FF,
  input  logic            mem_ready,
  input  logic            Stop,
  output logic            PCout, Zhighout, Zlowout, MDRout, InPortout,
  output logic            MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin,
  output logic            IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin,
  output logic [ALUW-1:0] alu_sel,
  output logic            Run,
  output logic            illegal_op,
  output logic            bus_err
);

  localparam logic [3:0] W_TMO = 4'(MEM_TIMEOUT);

  state_e     r_state;
  logic [3:0] r_wcnt;
  logic       r_bus_err;

  logic [OPW-1:0] w_op;
  op_class_e      w_cls;
  logic [3:0]     w_op_alu;
  logic [3:0]     w_alu;
  logic           w_wait, w_last, w_ill;
  state_e         w_nxt;
  ctl_t           w_ctl;
  logic           w_unused_ir;

  assign w_op        = IR[31 -: OPW];
  assign w_unused_ir = ^IR[26:0];

  control_sequencer_op_decoder u_dec (
    .i_op      (w_op),
    .o_cls     (w_cls),
    .o_alu_sel (w_op_alu)
  );

  // Steps that hold until memory answers, and steps that close an instruction
  assign w_wait = (r_state == ST_T1) ||
                  (r_state == ST_T6 && w_cls == C_LD) ||
                  (r_state == ST_T7 && w_cls == C_ST);
  assign w_last = (r_state == ST_T2 && (w_cls == C_NOP || w_cls == C_ILLEGAL)) ||
                  (r_state == ST_T5 && (w_cls == C_ALU_R || w_cls == C_ALU_I || w_cls == C_LDI)) ||
                  (r_state == ST_T6 && w_cls == C_BR) ||
                  (r_state == ST_T7 && (w_cls == C_LD || w_cls == C_ST));

  always_comb begin
    case (r_state)
      ST_RST:  w_nxt = ST_T0;
      ST_T0:   w_nxt = ST_T1;
      ST_T1:   w_nxt = ST_T2;
      ST_T2:   w_nxt = ST_T3;
      ST_T3:   w_nxt = ST_T4;
      ST_T4:   w_nxt = ST_T5;
      ST_T5:   w_nxt = ST_T6;
      ST_T6:   w_nxt = ST_T7;
      ST_T7:   w_nxt = ST_T0;
      ST_HALT: w_nxt = ST_HALT;
      default: w_nxt = ST_RST;
    endcase
    if (r_state == ST_T2 && w_cls == C_HALT) w_nxt = ST_HALT;
    else if (w_last)                         w_nxt = Stop ? ST_HALT : ST_T0;
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r_state   <= ST_RST;
      r_wcnt    <= '0;
      r_bus_err <= 1'b0;
    end else if (w_wait && !mem_ready) begin
      if (r_wcnt == W_TMO) begin
        r_bus_err <= 1'b1;
        r_state   <= ST_HALT;
        r_wcnt    <= '0;
      end else begin
        r_wcnt <= r_wcnt + 4'd1;
      end
    end else begin
      r_state <= w_nxt;
      r_wcnt  <= '0;
    end
  end

  // Moore strobe decode; only PCin in the branch T6 step looks at a live input
  always_comb begin
    w_ctl = '0;
    w_alu = ALU_ADD;
    w_ill = 1'b0;
    case (r_state)
      ST_T0: begin w_ctl.pc_out = 1'b1; w_ctl.mar_in = 1'b1; w_ctl.inc_pc = 1'b1; w_ctl.z_in = 1'b1; end
      ST_T1: begin w_ctl.zlo_out = 1'b1; w_ctl.pc_in = 1'b1; w_ctl.rd = 1'b1; w_ctl.mdr_in = 1'b1; end
      ST_T2: begin w_ctl.mdr_out = 1'b1; w_ctl.ir_in = 1'b1; w_ill = (w_cls == C_ILLEGAL); end
      ST_T3: case (w_cls)
        C_ALU_R, C_ALU_I:  begin w_ctl.grb = 1'b1; w_ctl.r_out = 1'b1; w_ctl.y_in = 1'b1; end
        C_LDI, C_LD, C_ST: begin w_ctl.grb = 1'b1; w_ctl.ba_out = 1'b1; w_ctl.y_in = 1'b1; end
        C_BR:              begin w_ctl.gra = 1'b1; w_ctl.r_out = 1'b1; w_ctl.con_in = 1'b1; end
        default: ;
      endcase
      ST_T4: case (w_cls)
        C_ALU_R:          begin w_ctl.grc = 1'b1; w_ctl.r_out = 1'b1; w_ctl.z_in = 1'b1; w_alu = w_op_alu; end
        C_ALU_I, C_LDI:   begin w_ctl.c_out = 1'b1; w_ctl.z_in = 1'b1; w_alu = w_op_alu; end
        C_LD, C_ST:       begin w_ctl.c_out = 1'b1; w_ctl.z_in = 1'b1; end
        C_BR:             begin w_ctl.pc_out = 1'b1; w_ctl.y_in = 1'b1; end
        default: ;
      endcase
      ST_T5: case (w_cls)
        C_ALU_R, C_ALU_I, C_LDI: begin w_ctl.zlo_out = 1'b1; w_ctl.gra = 1'b1; w_ctl.r_in = 1'b1; end
        C_LD, C_ST:              begin w_ctl.zlo_out = 1'b1; w_ctl.mar_in = 1'b1; end
        C_BR:                    begin w_ctl.c_out = 1'b1; w_ctl.z_in = 1'b1; end
        default: ;
      endcase
      ST_T6: case (w_cls)
        C_LD:    begin w_ctl.rd = 1'b1; w_ctl.mdr_in = 1'b1; end
        C_ST:    begin w_ctl.gra = 1'b1; w_ctl.r_out = 1'b1; w_ctl.mdr_in = 1'b1; end
        C_BR:    begin w_ctl.zlo_out = 1'b1; w_ctl.pc_in = CON_FF; end
        default: ;
      endcase
      ST_T7: case (w_cls)
        C_LD:    begin w_ctl.mdr_out = 1'b1; w_ctl.gra = 1'b1; w_ctl.r_in = 1'b1; end
        C_ST:    begin w_ctl.mdr_out = 1'b1; w_ctl.wr = 1'b1; end
        default: ;
      endcase
      default: ;
    endcase
  end

  assign {PCout, Zhighout, Zlowout, MDRout, InPortout} =
         {w_ctl.pc_out, w_ctl.zhi_out, w_ctl.zlo_out, w_ctl.mdr_out, w_ctl.inport_out};
  assign {MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin} =
         {w_ctl.mar_in, w_ctl.z_in, w_ctl.pc_in, w_ctl.mdr_in, w_ctl.ir_in, w_ctl.y_in, w_ctl.outport_in};
  assign {IncPC, Read, Write, Gra, Grb, Grc} =
         {w_ctl.inc_pc, w_ctl.rd, w_ctl.wr, w_ctl.gra, w_ctl.grb, w_ctl.grc};
  assign {Rin, Rout, BAout, Cout, CONin} =
         {w_ctl.r_in, w_ctl.r_out, w_ctl.ba_out, w_ctl.c_out, w_ctl.con_in};

  assign alu_sel    = ALUW'(w_alu);
  assign Run        = (r_state != ST_RST) && (r_state != ST_HALT);
  assign illegal_op = w_ill;
  assign bus_err    = r_bus_err;

endmodule

// File: tb/tb_control_sequencer.sv
// Random and directed instruction streams checked cycle by cycle against a
// per-instruction step-list model of the control sequencer.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Clear = 1'b0;
  logic [31:0] IR = '0;
  logic        CON_FF = 1'b0, mem_ready = 1'b0, Stop = 1'b0;
  logic PCout, Zhighout, Zlowout, MDRout, InPortout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin;
  logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin;
  logic [3:0] alu_sel;
  logic Run, illegal_op, bus_err;

  control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .mem_ready(mem_ready), .Stop(Stop),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout), .InPortout(InPortout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .OutPortin(OutPortin),
    .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
    .Rout(Rout), .BAout(BAout), .Cout(Cout), .CONin(CONin),
    .alu_sel(alu_sel), .Run(Run), .illegal_op(illegal_op), .bus_err(bus_err)
  );

  always #5 Clock = ~Clock;

  // Strobe bit positions in the observed vector (bit 22 = PCout ... bit 0 = CONin)
  localparam logic [22:0] PCO  = 23'd1 << 22, ZLO  = 23'd1 << 20, MDRO = 23'd1 << 19;
  localparam logic [22:0] MARI = 23'd1 << 17, ZI   = 23'd1 << 16, PCI  = 23'd1 << 15;
  localparam logic [22:0] MDRI = 23'd1 << 14, IRI  = 23'd1 << 13, YI   = 23'd1 << 12;
  localparam logic [22:0] INCP = 23'd1 << 10, RD   = 23'd1 << 9,  WR   = 23'd1 << 8;
  localparam logic [22:0] GRA  = 23'd1 << 7,  GRB  = 23'd1 << 6,  GRC  = 23'd1 << 5;
  localparam logic [22:0] RI   = 23'd1 << 4,  ROUT = 23'd1 << 3,  BAO  = 23'd1 << 2;
  localparam logic [22:0] COUT = 23'd1 << 1,  CONI = 23'd1 << 0;

  logic [29:0] obs;
  assign obs = {illegal_op, Run, bus_err, alu_sel,
                PCout, Zhighout, Zlowout, MDRout, InPortout,
                MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin,
                IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin};

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  typedef struct { logic [22:0] s; logic [3:0] alu; bit ill; bit wt; bit brpc; } stp_t;
  stp_t q[$];

  function automatic stp_t mk(logic [22:0] s, logic [3:0] alu, bit ill, bit wt, bit brpc);
    stp_t t;
    t.s = s; t.alu = alu; t.ill = ill; t.wt = wt; t.brpc = brpc;
    return t;
  endfunction

  // Step list for one instruction straight from the opcode table; hk = halt opcode
  function automatic void build(input logic [4:0] op, output bit hk);
    int k; logic [3:0] a;
    a = 4'd0; hk = 1'b0;
    case (op)
      5'b00011: k = 0;
      5'b00100: begin k = 0; a = 4'd1; end
      5'b00101: begin k = 0; a = 4'd2; end
      5'b00110: begin k = 0; a = 4'd3; end
      5'b01100: k = 1;
      5'b01101: begin k = 1; a = 4'd2; end
      5'b01110: begin k = 1; a = 4'd3; end
      5'b00001: k = 2;
      5'b00000: k = 3;
      5'b00010: k = 4;
      5'b10010: k = 5;
      5'b11010: k = 6;
      5'b11011: begin k = 7; hk = 1'b1; end
      default:  k = 8;
    endcase
    q.delete();
    q.push_back(mk(PCO | MARI | INCP | ZI, 0, 0, 0, 0));
    q.push_back(mk(ZLO | PCI | RD | MDRI, 0, 0, 1, 0));
    q.push_back(mk(MDRO | IRI, 0, k == 8, 0, 0));
    case (k)
      0, 1, 2: begin
        q.push_back(mk(GRB | ((k == 2) ? BAO : ROUT) | YI, 0, 0, 0, 0));
        q.push_back(mk(((k == 0) ? (GRC | ROUT) : COUT) | ZI, a, 0, 0, 0));
        q.push_back(mk(ZLO | GRA | RI, 0, 0, 0, 0));
      end
      3, 4: begin
        q.push_back(mk(GRB | BAO | YI, 0, 0, 0, 0));
        q.push_back(mk(COUT | ZI, 0, 0, 0, 0));
        q.push_back(mk(ZLO | MARI, 0, 0, 0, 0));
        if (k == 3) begin
          q.push_back(mk(RD | MDRI, 0, 0, 1, 0));
          q.push_back(mk(MDRO | GRA | RI, 0, 0, 0, 0));
        end else begin
          q.push_back(mk(GRA | ROUT | MDRI, 0, 0, 0, 0));
          q.push_back(mk(MDRO | WR, 0, 0, 1, 0));
        end
      end
      5: begin
        q.push_back(mk(GRA | ROUT | CONI, 0, 0, 0, 0));
        q.push_back(mk(PCO | YI, 0, 0, 0, 0));
        q.push_back(mk(COUT | ZI, 0, 0, 0, 0));
        q.push_back(mk(ZLO, 0, 0, 0, 1));
      end
      default: ;
    endcase
  endfunction

  // Entered and left at posedge+1. Clear goes low and is released here.
  task automatic do_reset();
    Clear = 1'b0; mem_ready = 1'b0;
    #1 chk("rst_async", 32'(obs), 32'd0);
    @(posedge Clock); #1;
    chk("rst_hold", 32'(obs), 32'd0);
    Clear = 1'b1;
    #1 chk("rst_release", 32'(obs), 32'd0);
    @(posedge Clock); #1;
  endtask

  // nlow >= 0 forces that many low mem_ready cycles in ld T6 / st T7;
  // abort_at >= 0 pulls Clear at that step index. hlt reports a model halt.
  task automatic run_instr(input logic [31:0] ir, input bit con, input bit stp,
                           input int nlow, input int abort_at, input string tag, output bit hlt);
    bit hk, to;
    logic [29:0] e;
    int waited;
    to = 1'b0;
    IR = ir; CON_FF = con; Stop = stp;
    build(ir[31:27], hk);
    foreach (q[i]) begin
      waited = 0;
      if (i == abort_at) begin
        Clear = 1'b0;
        #1 chk({tag, "_abort"}, 32'(obs), 32'd0);
        hlt = 1'b1;
        return;
      end
      for (int c = 0; c < 40; c++) begin
        if (q[i].wt)
          mem_ready = (i >= 2 && nlow >= 0) ? (waited >= nlow)
                    : ((waited >= 3) ? 1'b1 : 1'($urandom_range(0, 1)));
        else
          mem_ready = 1'($urandom_range(0, 1));
        e = {q[i].ill, 1'b1, 1'b0, q[i].alu, q[i].s | ((q[i].brpc && con) ? PCI : 23'd0)};
        #1 chk($sformatf("%s_t%0d", tag, i), 32'(obs), 32'(e));
        @(posedge Clock); #1;
        if (!(q[i].wt && !mem_ready)) break;
        waited++;
        if (waited == 16) begin to = 1'b1; break; end
      end
      if (to) break;
    end
    hlt = to | hk | stp;
    if (hlt) begin
      for (int c = 0; c < 3; c++) begin
        mem_ready = 1'($urandom_range(0, 1));
        #1 chk({tag, "_halted"}, 32'(obs), 32'({1'b0, 1'b0, to, 4'd0, 23'd0}));
        @(posedge Clock); #1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bit h;
    logic [31:0] ir;
    logic [4:0] ops [13] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
                             5'b01100, 5'b01101, 5'b01110, 5'b10010, 5'b11010, 5'b11111};
    do_reset();
    run_instr(32'h0880_0055, 0, 0, -1, -1, "ldi", h);
    run_instr(32'h1891_8000, 0, 0, -1, -1, "add", h);
    run_instr(32'h2091_8000, 0, 0, -1, -1, "sub", h);
    run_instr(32'h2891_8000, 0, 0, -1, -1, "and", h);
    run_instr(32'h7091_0007, 0, 0, -1, -1, "ori", h);
    run_instr(32'h0080_0010, 0, 0,  3, -1, "ld_wait3", h);
    run_instr(32'h1080_0010, 0, 0,  2, -1, "st_wait2", h);
    run_instr(32'h9080_0004, 0, 0, -1, -1, "br_con0", h);
    run_instr(32'h9080_0004, 1, 0, -1, -1, "br_con1", h);
    run_instr(32'hF800_0000, 0, 0, -1, -1, "illegal", h);
    run_instr(32'hD000_0000, 0, 0, -1, -1, "nop", h);
    run_instr(32'hD800_0000, 0, 0, -1, -1, "halt", h);
    do_reset();
    run_instr(32'hD800_0000, 0, 1, -1, -1, "halt_stop", h);
    do_reset();
    run_instr(32'h1891_8000, 0, 1, -1, -1, "add_stop", h);
    do_reset();
    run_instr(32'h0080_0010, 0, 0, -1, 5, "ld_abort", h);
    do_reset();
    run_instr(32'h0880_0055, 0, 0, -1, -1, "ldi_restart", h);
    run_instr(32'h0080_0010, 0, 0, 16, -1, "ld_timeout", h);
    do_reset();
    chk("bus_err_cleared", 32'(bus_err), 32'd0);
    for (int n = 0; n < 80; n++) begin
      ir = $urandom;
      if ($urandom_range(0, 3) != 0) ir[31:27] = ops[$urandom_range(0, 12)];
      run_instr(ir, 1'($urandom_range(0, 1)), $urandom_range(0, 11) == 0, -1, -1, "rnd", h);
      if (h) do_reset();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
